// File: rtl/unique_set_serializer.sv
// Snapshots the tracker's unique-value list on change and streams its valid entries, one per beat.
// Latency: first beat valid 1 cycle after a change; backpressure: beat held while !ready_in, mid-frame changes coalesce into one pending snapshot.
module unique_set_serializer #(
  parameter int WIDTH = 8,
  parameter int NUM = 4,
  localparam int IW = $clog2(NUM)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [NUM*WIDTH-1:0] set_in,
  input  logic [NUM-1:0]       set_valid_in,
  output logic [WIDTH-1:0]     data_out,
  output logic [IW-1:0]        index_out,
  output logic                 valid_out,
  output logic                 last_out,
  input  logic                 ready_in,
  output logic                 busy_out,
  output logic [15:0]          drop_cnt_out
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nxt;

  logic [NUM*WIDTH-1:0] seen_set, pend_set, snap_set, load_set;
  logic [NUM-1:0]       seen_mask, pend_mask, snap_mask, load_mask;
  logic                 pending;
  logic [IW-1:0]        ptr;
  logic                 worthy, accept, last_c;
  logic                 load_en, load_pend, pend_wr, pend_clr, drop_inc;

  function automatic logic [IW-1:0] first_valid(input logic [NUM-1:0] m, input int start);
    logic [IW-1:0] r;
    r = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (k >= start && m[k]) r = IW'(k);
    end
    return r;
  endfunction

  always_comb begin
    last_c = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      if (k > int'(ptr) && snap_mask[k]) last_c = 1'b0;
    end
  end

  assign worthy    = ({set_in, set_valid_in} != {seen_set, seen_mask}) && (set_valid_in != '0);
  assign valid_out = (state == SEND);
  assign busy_out  = (state == SEND);
  assign accept    = valid_out && ready_in;
  assign last_out  = valid_out && last_c;
  assign data_out  = snap_set[int'(ptr)*WIDTH +: WIDTH];
  assign index_out = ptr;

  // A new snapshot may load whenever idle or on the edge that retires the final beat,
  // so a pending snapshot follows its predecessor without a bubble.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    load_pend = 1'b0;
    pend_wr   = 1'b0;
    pend_clr  = 1'b0;
    drop_inc  = 1'b0;
    if (state == IDLE || (accept && last_c)) begin
      state_nxt = IDLE;
      if (pending) begin
        load_en   = 1'b1;
        load_pend = 1'b1;
        state_nxt = SEND;
        pend_wr   = worthy;
        pend_clr  = !worthy;
      end else if (worthy) begin
        load_en   = 1'b1;
        state_nxt = SEND;
      end
    end else if (worthy) begin
      pend_wr  = 1'b1;
      drop_inc = pending;
    end
    load_set  = load_pend ? pend_set  : set_in;
    load_mask = load_pend ? pend_mask : set_valid_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      seen_set     <= '0;
      seen_mask    <= '0;
      pend_set     <= '0;
      pend_mask    <= '0;
      pending      <= 1'b0;
      snap_set     <= '0;
      snap_mask    <= '0;
      ptr          <= '0;
      drop_cnt_out <= '0;
    end else begin
      seen_set  <= set_in;
      seen_mask <= set_valid_in;
      if (load_en) begin
        snap_set  <= load_set;
        snap_mask <= load_mask;
        ptr       <= first_valid(load_mask, 0);
      end else if (accept) begin
        ptr <= first_valid(snap_mask, int'(ptr) + 1);
      end
      if (pend_wr) begin
        pend_set  <= set_in;
        pend_mask <= set_valid_in;
        pending   <= 1'b1;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
      if (drop_inc && drop_cnt_out != 16'hFFFF) drop_cnt_out <= drop_cnt_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_unique_set_serializer.sv
// Bench for unique_set_serializer: directed scenarios plus randomized frames vs. a list-level model.
module tb_unique_set_serializer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] set_in;
  logic [3:0]  set_valid_in;
  logic [7:0]  data_out;
  logic [1:0]  index_out;
  logic        valid_out, last_out, ready_in, busy_out;
  logic [15:0] drop_cnt_out;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  beat_t beats[$];
  beat_t exp_q[$];
  bit    vhist[$];
  int    n_assert = 0;
  int    n_fail = 0;

  unique_set_serializer #(.WIDTH(8), .NUM(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .set_in(set_in), .set_valid_in(set_valid_in),
    .data_out(data_out), .index_out(index_out), .valid_out(valid_out), .last_out(last_out),
    .ready_in(ready_in), .busy_out(busy_out), .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (valid_out && ready_in) beats.push_back('{data_out, index_out, last_out});
    vhist.push_back(valid_out);
  end

  // Model: a frame is the valid entries in ascending index; last is the highest set mask bit.
  task automatic add_frame(input logic [31:0] s, input logic [3:0] m);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        b.d    = s[k*8 +: 8];
        b.idx  = k[1:0];
        b.last = ((m >> (k + 1)) == 4'd0);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] s, input logic [3:0] m);
    set_in = s;
    set_valid_in = m;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; ready_in = 1'b1; drive(32'h0, 4'h0);
    step(); step();
    @(negedge clk_in);
    n_assert++;
    if ({valid_out, last_out, busy_out, data_out, index_out, drop_cnt_out} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b l=%b b=%b d=%h i=%0d drop=%0d, want all zero",
               valid_out, last_out, busy_out, data_out, index_out, drop_cnt_out);
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    int busy_cycles = 0;
    beats.delete(); exp_q.delete();
    add_frame(32'h04030201, 4'b1111);
    drive(32'h04030201, 4'b1111);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (busy_out) busy_cycles++;
      step();
    end
    n_assert++;
    if (busy_cycles != 4) begin
      n_fail++;
      $display("FAIL full_busy_cycles: got %0d want 4", busy_cycles);
    end
    n_assert++;
    if (beats.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_len: got %0d want %0d", beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_assert++;
        if (beats[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL full_beat%0d: got %h want %h", i, beats[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_sparse();
    int busy_cycles = 0;
    beats.delete(); exp_q.delete();
    add_frame(32'h773C11A5, 4'b0101);
    drive(32'h773C11A5, 4'b0101);
    repeat (6) step();
    drive(32'h773C11A5, 4'b0000);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (busy_out) busy_cycles++;
      step();
    end
    n_assert++;
    if (busy_cycles != 0) begin
      n_fail++;
      $display("FAIL sparse_all_invalid_frame: got %0d busy cycles want 0", busy_cycles);
    end
    n_assert++;
    if (beats.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sparse_len: got %0d want %0d", beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_assert++;
        if (beats[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL sparse_beat%0d: got %h want %h", i, beats[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    beats.delete(); exp_q.delete();
    add_frame(32'h44332211, 4'b1111);
    drive(32'h44332211, 4'b1111);
    step();
    step();
    ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      n_assert++;
      if ({valid_out, data_out, index_out, last_out} !== {1'b1, exp_q[1]}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b %h want v=1 %h", c, valid_out,
                 {data_out, index_out, last_out}, exp_q[1]);
      end
      step();
    end
    ready_in = 1'b1;
    repeat (6) step();
    n_assert++;
    if (beats.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stall_len: got %0d want %0d", beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_assert++;
        if (beats[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %h want %h", i, beats[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mid_frame();
    int first = -1, last = -1, ones = 0;
    beats.delete(); exp_q.delete(); vhist.delete();
    add_frame(32'h0D0C0B0A, 4'b1111);
    add_frame(32'h2D2C2B2A, 4'b1010);
    drive(32'h0D0C0B0A, 4'b1111);
    step();
    drive(32'h1D1C1B1A, 4'b0111);
    step();
    drive(32'h2D2C2B2A, 4'b1010);
    repeat (10) step();
    for (int i = 0; i < vhist.size(); i++) begin
      if (vhist[i]) begin
        if (first < 0) first = i;
        last = i;
        ones++;
      end
    end
    n_assert++;
    if (drop_cnt_out !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_drop_cnt: got %0d want 1", drop_cnt_out);
    end
    n_assert++;
    if (ones != 6 || (last - first + 1) != ones) begin
      n_fail++;
      $display("FAIL mid_valid_run: got %0d valid cycles span %0d want 6 contiguous", ones, last - first + 1);
    end
    n_assert++;
    if (beats.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL mid_len: got %0d want %0d", beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_assert++;
        if (beats[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL mid_beat%0d: got %h want %h", i, beats[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    beats.delete(); exp_q.delete();
    add_frame(32'h55667788, 4'b1001);
    drive(32'h55667788, 4'b1001);
    repeat (25) step();
    n_assert++;
    if (drop_cnt_out !== 16'd1) begin
      n_fail++;
      $display("FAIL hold_drop_cnt: got %0d want 1", drop_cnt_out);
    end
    n_assert++;
    if (beats.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL hold_len: got %0d want %0d", beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_assert++;
        if (beats[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL hold_beat%0d: got %h want %h", i, beats[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(32'h9A9B9C9D, 4'b1111);
    step();
    drive(32'h01020304, 4'b1111);
    step();
    rst_in = 1'b1;
    step();
    @(negedge clk_in);
    n_assert++;
    if ({valid_out, busy_out, drop_cnt_out} !== 18'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state: got v=%b b=%b drop=%0d want 0 0 0", valid_out, busy_out, drop_cnt_out);
    end
    beats.delete(); exp_q.delete();
    add_frame(32'h01020304, 4'b1111);
    rst_in = 1'b0;
    repeat (10) step();
    n_assert++;
    if (beats.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rst_mid_len: got %0d want %0d", beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_assert++;
        if (beats[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rst_mid_beat%0d: got %h want %h", i, beats[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] s, prev_s;
    logic [3:0]  m, prev_m;
    bit          done;
    prev_s = set_in;
    prev_m = set_valid_in;
    for (int it = 0; it < 25; it++) begin
      do begin
        s = $urandom;
        m = 4'($urandom_range(1, 15));
      end while ({s, m} == {prev_s, prev_m});
      prev_s = s; prev_m = m;
      beats.delete(); exp_q.delete();
      add_frame(s, m);
      drive(s, m);
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        ready_in = 1'($urandom_range(0, 1));
        step();
        if (c > 0 && !busy_out) done = 1'b1;
      end
      ready_in = 1'b1;
      n_assert++;
      if (!done) begin
        n_fail++;
        $display("FAIL rand%0d_timeout: frame still busy after 300 cycles", it);
      end
      n_assert++;
      if (beats.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_len: got %0d want %0d", it, beats.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_assert++;
          if (beats[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, beats[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_sparse();
    test_backpressure();
    test_mid_frame();
    test_hold();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
